// File: rtl/ifetch_prefetch.sv
// ifetch_prefetch: sequential instruction prefetcher with an in-order response
// queue and a redirect (branch/jump) flush path.
//
// Optional build macro: IFETCH_MISALIGN_TRAP_EN
//   defined   : a misaligned redirect target parks the block in HALT and queues
//               one marker entry {pc=target, data=0, misaligned=1}.
//   undefined : redirect targets are forced to word alignment; HALT unused.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | first cycle after reset release, no requests
// RUN   | normal sequential fetching
// HALT  | misaligned target pending, leaves only through a redirect
module ifetch_prefetch #(
    parameter int unsigned     XLEN            = 32,
    parameter int unsigned     DEPTH           = 4,
    parameter int unsigned     MAX_OUTSTANDING = 2,
    parameter logic [XLEN-1:0] RESET_PC        = '0
) (
    input  logic            clk,
    input  logic            cpu_rstn,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            req_valid,
    input  logic            req_ready,
    output logic [XLEN-1:0] req_addr,
    input  logic            rsp_valid,
    input  logic [XLEN-1:0] rsp_data,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instr_data,
    output logic [XLEN-1:0] instr_pc,
    output logic            instr_misaligned
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned SW = CW + 1;
    localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);

    localparam logic [OW-1:0] MAX_OUT = OW'(MAX_OUTSTANDING);
    localparam logic [SW-1:0] DEPTH_C = SW'(DEPTH);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;

    logic [1:0]      state;
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] resp_pc;
    logic [OW-1:0]   outstanding;
    logic [OW-1:0]   outstanding_next;
    logic [OW-1:0]   discard;
    logic [CW-1:0]   count;
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [SW-1:0]   credit_sum;

    logic [XLEN-1:0] q_data [DEPTH];
    logic [XLEN-1:0] q_pc   [DEPTH];

    logic            redirect_eff;
    logic [XLEN-1:0] target_pc;
    logic            mis_tgt;
    logic            mis_push;
    logic            accept;
    logic            rsp_ok;
    logic            rsp_push;
    logic            push;
    logic            pop;

`ifdef IFETCH_MISALIGN_TRAP_EN
    logic             mis_pending;
    logic [DEPTH-1:0] q_mis;

    assign target_pc        = redirect_pc;
    assign mis_tgt          = (redirect_pc[1:0] != 2'b00);
    assign mis_push         = (state == ST_HALT) && mis_pending && (discard == '0) && !redirect_eff;
    assign instr_misaligned = q_mis[rd_ptr];
`else
    logic unused_pc_lsb;

    assign unused_pc_lsb    = ^redirect_pc[1:0];
    assign target_pc        = {redirect_pc[XLEN-1:2], 2'b00};
    assign mis_tgt          = 1'b0;
    assign mis_push         = 1'b0;
    assign instr_misaligned = 1'b0;
`endif

    // Redirects are ignored only while the block is still in IDLE.
    assign redirect_eff = redirect_valid && (state != ST_IDLE);

    // Credit check counts in-flight requests against free queue slots, so a
    // response always has somewhere to land.
    assign credit_sum = SW'(outstanding) + SW'(count);
    assign req_valid  = (state == ST_RUN) && !redirect_valid &&
                        (outstanding < MAX_OUT) && (credit_sum < DEPTH_C);
    assign req_addr   = fetch_pc;

    assign accept           = req_valid && req_ready;
    assign rsp_ok           = rsp_valid && (outstanding != '0);
    assign outstanding_next = outstanding + OW'(accept) - OW'(rsp_ok);
    assign rsp_push         = rsp_ok && (discard == '0);
    assign push             = rsp_push || mis_push;
    assign pop              = instr_valid && instr_ready;

    assign instr_valid = (count != '0);
    assign instr_data  = q_data[rd_ptr];
    assign instr_pc    = q_pc[rd_ptr];

    // Control state: FSM, fetch/response PCs, in-flight and discard counters.
    always_ff @(posedge clk or negedge cpu_rstn) begin
        if (!cpu_rstn) begin
            state       <= ST_IDLE;
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
`ifdef IFETCH_MISALIGN_TRAP_EN
            mis_pending <= 1'b0;
`endif
        end else begin
            outstanding <= outstanding_next;
            if (redirect_eff) begin
                fetch_pc <= target_pc;
                resp_pc  <= target_pc;
                // Every request still unanswered after this edge belongs to
                // the old stream; a response landing right now is dropped.
                discard  <= outstanding_next;
                state    <= mis_tgt ? ST_HALT : ST_RUN;
`ifdef IFETCH_MISALIGN_TRAP_EN
                mis_pending <= mis_tgt;
`endif
            end else begin
                if (accept) begin
                    fetch_pc <= fetch_pc + XLEN'(4);
                end
                if (rsp_ok && (discard != '0)) begin
                    discard <= discard - OW'(1);
                end
                if (rsp_push) begin
                    resp_pc <= resp_pc + XLEN'(4);
                end
                if (state == ST_IDLE) begin
                    state <= ST_RUN;
                end
`ifdef IFETCH_MISALIGN_TRAP_EN
                if (mis_push) begin
                    mis_pending <= 1'b0;
                end
`endif
            end
        end
    end

    // Instruction queue: circular buffer, flushed by redirect.
    always_ff @(posedge clk or negedge cpu_rstn) begin
        if (!cpu_rstn) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                q_data[i] <= '0;
                q_pc[i]   <= '0;
            end
`ifdef IFETCH_MISALIGN_TRAP_EN
            q_mis <= '0;
`endif
        end else if (redirect_eff) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                q_data[wr_ptr] <= mis_push ? '0 : rsp_data;
                q_pc[wr_ptr]   <= resp_pc;
`ifdef IFETCH_MISALIGN_TRAP_EN
                q_mis[wr_ptr]  <= mis_push;
`endif
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

`ifndef SYNTHESIS
    // A response with nothing in flight means the memory side broke protocol.
    rsp_without_request : assert property (@(posedge clk) disable iff (!cpu_rstn)
        !(rsp_valid && (outstanding == '0)));
`endif

endmodule

// File: tb/tb_ifetch_prefetch.sv
// tb_ifetch_prefetch: table-driven and scoreboard bench for ifetch_prefetch
// with a 1-cycle-latency memory model.
module tb_ifetch_prefetch;

    logic        clk            = 1'b0;
    logic        cpu_rstn       = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc    = '0;
    logic        req_valid;
    logic        req_ready      = 1'b0;
    logic [31:0] req_addr;
    logic        rsp_valid      = 1'b0;
    logic [31:0] rsp_data       = '0;
    logic        instr_valid;
    logic        instr_ready    = 1'b0;
    logic [31:0] instr_data;
    logic [31:0] instr_pc;
    logic        instr_misaligned;

    always #5 clk = ~clk;

    ifetch_prefetch dut (
        .clk              (clk),
        .cpu_rstn         (cpu_rstn),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_addr         (req_addr),
        .rsp_valid        (rsp_valid),
        .rsp_data         (rsp_data),
        .instr_valid      (instr_valid),
        .instr_ready      (instr_ready),
        .instr_data       (instr_data),
        .instr_pc         (instr_pc),
        .instr_misaligned (instr_misaligned)
    );

    typedef struct { logic [31:0] pc; logic [31:0] data; logic mis; } exp_t;
    typedef struct { logic [31:0] addr; int cyc; } mreq_t;
    typedef struct { bit rr; bit ir; bit exp_rv; logic [31:0] exp_addr; bit exp_iv; } vec_t;

    exp_t        sb[$];
    mreq_t       mem_q[$];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    int          pops = 0;
    int          since_redir = 0;
    logic [31:0] exp_fetch = '0;
    logic [31:0] first_pc = '0;
    logic [31:0] second_pc = '0;
    logic        first_mis = 1'b0;
    bit          halted = 1'b0;
    bit          rsp_en = 1'b1;

    function automatic logic [31:0] data_of(input logic [31:0] a);
        return {a[15:0], 16'h0} ^ (a >> 2) ^ 32'h0000_0013;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Reference model and scoreboard update for the current (settled) cycle.
    task automatic observe();
        exp_t e;
        if (rsp_valid) void'(mem_q.pop_front());
        if (instr_valid && instr_ready) begin
            pops++;
            if (since_redir == 0) begin
                first_pc  = instr_pc;
                first_mis = instr_misaligned;
            end
            if (since_redir == 1) second_pc = instr_pc;
            since_redir++;
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_pop: got pc %h, required no entry", instr_pc);
            end else begin
                e = sb.pop_front();
                check("pop_pc", instr_pc, e.pc);
                check("pop_data", instr_data, e.data);
                check("pop_mis", 32'(instr_misaligned), 32'(e.mis));
            end
        end
        if (req_valid) check("req_addr", req_addr, exp_fetch);
        if (halted) check("halt_req_valid", 32'(req_valid), 32'd0);
        if (req_valid && req_ready) begin
            mem_q.push_back('{addr: req_addr, cyc: cyc});
            sb.push_back('{pc: exp_fetch, data: data_of(exp_fetch), mis: 1'b0});
            exp_fetch = exp_fetch + 32'd4;
        end
        if (redirect_valid) begin
            sb.delete();
            since_redir = 0;
`ifdef IFETCH_MISALIGN_TRAP_EN
            exp_fetch = redirect_pc;
            halted    = (redirect_pc[1:0] != 2'b00);
            if (halted) sb.push_back('{pc: redirect_pc, data: 32'd0, mis: 1'b1});
`else
            exp_fetch = {redirect_pc[31:2], 2'b00};
`endif
        end
    endtask

    task automatic cycle_x(input bit rr, input bit ir, input bit rv, input logic [31:0] rpc,
                           input bit rv_on_both, output bit fired);
        bit rsp_now;
        @(negedge clk);
        cyc++;
        rsp_now = rsp_en && (mem_q.size() > 0);
        if (rsp_now) rsp_now = (mem_q[0].cyc < cyc);
        fired = rv || (rv_on_both && rsp_now && instr_valid && ir);
        req_ready      = rr;
        instr_ready    = ir;
        redirect_valid = fired;
        redirect_pc    = rpc;
        rsp_valid      = rsp_now;
        if (rsp_now) rsp_data = data_of(mem_q[0].addr);
        else         rsp_data = 32'd0;
        #1;
        observe();
    endtask

    task automatic step(input bit rr, input bit ir);
        bit f;
        cycle_x(rr, ir, 1'b0, 32'd0, 1'b0, f);
    endtask

    task automatic redir(input logic [31:0] rpc);
        bit f;
        cycle_x(1'b1, 1'b1, 1'b1, rpc, 1'b0, f);
    endtask

    task automatic wait_pops(input string name, input int n);
        int k = 0;
        while (since_redir < n && k < 40) begin
            step(1'b1, 1'b1);
            k++;
        end
        check(name, 32'(since_redir >= n), 32'd1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        cpu_rstn       = 1'b0;
        req_ready      = 1'b0;
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        rsp_valid      = 1'b0;
        rsp_data       = '0;
        #1;
        check("rst_req_valid", 32'(req_valid), 32'd0);
        check("rst_instr_valid", 32'(instr_valid), 32'd0);
        check("rst_misaligned", 32'(instr_misaligned), 32'd0);
        check("rst_req_addr", req_addr, 32'd0);
        check("rst_instr_data", instr_data, 32'd0);
        check("rst_instr_pc", instr_pc, 32'd0);
        mem_q.delete();
        sb.delete();
        exp_fetch   = '0;
        halted      = 1'b0;
        since_redir = 0;
        rsp_en      = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        cpu_rstn = 1'b1;
        #1;
        check("idle_req_valid", 32'(req_valid), 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[8];
        bit   fired;
        int   p0;
        int   k;

        vt[0] = '{1'b1, 1'b0, 1'b1, 32'h00, 1'b0};
        vt[1] = '{1'b1, 1'b0, 1'b1, 32'h04, 1'b0};
        vt[2] = '{1'b1, 1'b0, 1'b1, 32'h08, 1'b1};
        vt[3] = '{1'b1, 1'b0, 1'b1, 32'h0C, 1'b1};
        vt[4] = '{1'b1, 1'b0, 1'b0, 32'h10, 1'b1};
        vt[5] = '{1'b1, 1'b0, 1'b0, 32'h10, 1'b1};
        vt[6] = '{1'b1, 1'b1, 1'b0, 32'h10, 1'b1};
        vt[7] = '{1'b1, 1'b1, 1'b1, 32'h10, 1'b1};

        do_reset();

        // Start-up, fill with decoder stalled, then release.
        for (int i = 0; i < 8; i++) begin
            step(vt[i].rr, vt[i].ir);
            check($sformatf("tbl%0d_req_valid", i), 32'(req_valid), 32'(vt[i].exp_rv));
            check($sformatf("tbl%0d_req_addr", i), req_addr, vt[i].exp_addr);
            check($sformatf("tbl%0d_instr_valid", i), 32'(instr_valid), 32'(vt[i].exp_iv));
        end

        // Steady state streams one instruction per cycle.
        repeat (6) step(1'b1, 1'b1);
        p0 = pops;
        repeat (10) step(1'b1, 1'b1);
        check("throughput_pops", 32'(pops - p0), 32'd10);

        // Two requests in flight, then redirect; both responses are dropped.
        rsp_en = 1'b0;
        repeat (4) step(1'b1, 1'b1);
        check("inflight_count", 32'(mem_q.size()), 32'd2);
        redir(32'h100);
        rsp_en = 1'b1;
        step(1'b1, 1'b1);
        check("flush_empty_1", 32'(instr_valid), 32'd0);
        step(1'b1, 1'b1);
        check("flush_empty_2", 32'(instr_valid), 32'd0);
        wait_pops("redir1_wait", 1);
        check("redir1_first_pc", first_pc, 32'h100);

        // Redirect coinciding with a response and an instruction handshake.
        repeat (5) step(1'b1, 1'b1);
        fired = 1'b0;
        k = 0;
        while (!fired && k < 20) begin
            p0 = pops;
            cycle_x(1'b1, 1'b1, 1'b0, 32'h200, 1'b1, fired);
            k++;
        end
        check("redir2_fired", 32'(fired), 32'd1);
        check("redir2_pop_counts", 32'(pops - p0), 32'd1);
        wait_pops("redir2_wait", 1);
        check("redir2_first_pc", first_pc, 32'h200);

        // Address wrap at the top of the space.
        redir(32'hFFFF_FFFC);
        wait_pops("wrap_wait", 2);
        check("wrap_first_pc", first_pc, 32'hFFFF_FFFC);
        check("wrap_second_pc", second_pc, 32'h0000_0000);

        // Misaligned redirect target.
        redir(32'h102);
        wait_pops("mis_wait", 1);
`ifdef IFETCH_MISALIGN_TRAP_EN
        check("mis_first_pc", first_pc, 32'h102);
        check("mis_first_flag", 32'(first_mis), 32'd1);
        repeat (6) step(1'b1, 1'b1);
        check("mis_halt_empty", 32'(instr_valid), 32'd0);
        redir(32'h200);
        wait_pops("mis_resume_wait", 1);
        check("mis_resume_pc", first_pc, 32'h200);
`else
        check("mis_first_pc", first_pc, 32'h100);
        check("mis_first_flag", 32'(first_mis), 32'd0);
`endif

        // Drain everything still in flight.
        k = 0;
        while (sb.size() > 0 && k < 30) begin
            step(1'b0, 1'b1);
            k++;
        end
        check("drain_empty", 32'(sb.size()), 32'd0);

        // Reset in the middle of streaming.
        repeat (5) step(1'b1, 1'b1);
        do_reset();
        wait_pops("post_rst_wait", 2);
        check("post_rst_first_pc", first_pc, 32'h0);
        check("post_rst_second_pc", second_pc, 32'h4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
